// File: rtl/otf_pkg.sv
// Shared definitions for the on-the-fly conversion controller.
package otf_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FIRST,
        CONVERT,
        CAPTURE,
        HOLD
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_GAP     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_ILLEGAL = 2'd3;

    // Result word width: each signed digit contributes RADIX_BITS-1 bits.
    function automatic int w_of(input int no_of_digits, input int radix_bits);
        return no_of_digits * (radix_bits - 1);
    endfunction

endpackage

// File: rtl/otf_conversion_controller.sv
// Sequences one word of signed-digit conversion through an external
// on-the-fly converter: streams digits in, captures Q, hands it out over
// valid/ready, and flags stream gap / start timeout / illegal digit.
module otf_conversion_controller
    import otf_pkg::*;
#(
    parameter int NO_OF_DIGITS  = 8,
    parameter int RADIX_BITS    = 3,
    parameter int FIRST_TIMEOUT = 15
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        start,
    output logic                                        start_ready,
    input  logic                                        abort,
    input  logic [RADIX_BITS-1:0]                       in_digit,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    output logic [RADIX_BITS-1:0]                       conv_digit,
    output logic                                        conv_reset,
    input  logic [w_of(NO_OF_DIGITS, RADIX_BITS)-1:0]   conv_q,
    output logic [w_of(NO_OF_DIGITS, RADIX_BITS)-1:0]   res_data,
    output logic                                        res_valid,
    input  logic                                        res_ready,
    output logic                                        err,
    output logic [1:0]                                  err_code
);

    localparam int CNT_W = $clog2(NO_OF_DIGITS + 1);
    localparam int TO_W  = $clog2(FIRST_TIMEOUT + 1);

    localparam logic [CNT_W-1:0]      CNT_LAST     = CNT_W'(NO_OF_DIGITS - 1);
    localparam logic [TO_W-1:0]       TO_LAST      = TO_W'(FIRST_TIMEOUT - 1);
    localparam logic [RADIX_BITS-1:0] ILLEGAL_CODE = {1'b1, {(RADIX_BITS-1){1'b0}}};

    state_t           state;
    logic [CNT_W-1:0] digit_cnt;
    logic [TO_W-1:0]  timeout_cnt;

    logic             accept;
    logic             err_hit;
    logic [1:0]       err_sel;

    assign start_ready = (state == IDLE);
    assign in_ready    = (state == WAIT_FIRST) || (state == CONVERT);
    assign accept      = in_valid && in_ready;
    assign conv_digit  = accept ? in_digit : '0;
    assign err_hit     = (err_sel != ERR_NONE);
    assign conv_reset  = (state == IDLE) || abort || err_hit;

    // Error detection for the current cycle; illegal digit outranks gap/timeout.
    always_comb begin
        err_sel = ERR_NONE;
        if (accept && (in_digit == ILLEGAL_CODE))
            err_sel = ERR_ILLEGAL;
        else if ((state == CONVERT) && !in_valid)
            err_sel = ERR_GAP;
        else if ((state == WAIT_FIRST) && !in_valid && (timeout_cnt == TO_LAST))
            err_sel = ERR_TIMEOUT;
    end

    // Control FSM with digit/timeout counters and registered result/error outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            digit_cnt   <= '0;
            timeout_cnt <= '0;
            res_data    <= '0;
            res_valid   <= 1'b0;
            err         <= 1'b0;
            err_code    <= ERR_NONE;
        end else begin
            err <= 1'b0;
            if (abort) begin
                state     <= IDLE;
                res_valid <= 1'b0;
            end else if (err_hit) begin
                state     <= IDLE;
                res_valid <= 1'b0;
                err       <= 1'b1;
                err_code  <= err_sel;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state       <= WAIT_FIRST;
                            digit_cnt   <= '0;
                            timeout_cnt <= '0;
                            err_code    <= ERR_NONE;
                        end
                    end
                    WAIT_FIRST: begin
                        if (in_valid) begin
                            digit_cnt <= CNT_W'(1);
                            state     <= (NO_OF_DIGITS == 1) ? CAPTURE : CONVERT;
                        end else begin
                            // Cannot wrap: the last count raises a timeout instead.
                            timeout_cnt <= timeout_cnt + TO_W'(1);
                        end
                    end
                    CONVERT: begin
                        // in_valid is guaranteed here; a gap was handled as an error.
                        digit_cnt <= digit_cnt + CNT_W'(1);
                        if (digit_cnt == CNT_LAST)
                            state <= CAPTURE;
                    end
                    CAPTURE: begin
                        res_data  <= conv_q;
                        res_valid <= 1'b1;
                        state     <= HOLD;
                    end
                    HOLD: begin
                        if (res_ready) begin
                            res_valid <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_otf_conversion_controller.sv
// Bench for otf_conversion_controller with a behavioural on-the-fly
// converter (Q <= Q*4 + digit, synchronous clear) standing in for the
// real one, so the controller is exercised as in otf_conv_top.
module tb_otf_conversion_controller;

    localparam int N  = 8;
    localparam int RB = 3;
    localparam int W  = 16;

    typedef logic [RB-1:0] digits_t [N];

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          start_ready;
    logic          abort;
    logic [RB-1:0] in_digit;
    logic          in_valid;
    logic          in_ready;
    logic [RB-1:0] conv_digit;
    logic          conv_reset;
    logic [W-1:0]  conv_q;
    logic [W-1:0]  res_data;
    logic          res_valid;
    logic          res_ready;
    logic          err;
    logic [1:0]    err_code;

    int unsigned n_cmp = 0;
    int unsigned n_mis = 0;
    logic [W-1:0] exp_q[$];

    otf_conversion_controller #(
        .NO_OF_DIGITS (N),
        .RADIX_BITS   (RB),
        .FIRST_TIMEOUT(15)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .start_ready(start_ready),
        .abort      (abort),
        .in_digit   (in_digit),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .conv_digit (conv_digit),
        .conv_reset (conv_reset),
        .conv_q     (conv_q),
        .res_data   (res_data),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .err        (err),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    // Behavioural converter: radix-4 accumulate with synchronous clear.
    always_ff @(posedge clk) begin
        if (conv_reset)
            conv_q <= '0;
        else
            conv_q <= (conv_q << (RB - 1)) + {{(W-RB){conv_digit[RB-1]}}, conv_digit};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] ref_word(input digits_t d);
        int v = 0;
        for (int i = 0; i < N; i++) begin
            logic signed [RB-1:0] sd = d[i];
            v = v * 4 + int'(sd);
        end
        return v[W-1:0];
    endfunction

    // Drive one full word back-to-back, then hold the result for hold_cycles
    // (with a stray start) before releasing it, or reset instead of releasing.
    task automatic run_word(input string tag, input digits_t d, input logic [W-1:0] exp,
                            input int hold_cycles, input bit reset_in_hold);
        int edges;
        logic [W-1:0] e;
        check({tag, ".start_ready"}, start_ready, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        edges = 1;
        for (int i = 0; i < N; i++) begin
            in_valid = 1'b1;
            in_digit = d[i];
            tick();
            edges++;
        end
        in_valid = 1'b0;
        in_digit = '0;
        exp_q.push_back(exp);
        check({tag, ".rv_early"}, res_valid, 0);
        while (!res_valid && edges < 30) begin
            tick();
            edges++;
        end
        check({tag, ".latency"}, edges, N + 2);
        if (res_valid) begin
            e = exp_q.pop_front();
            check({tag, ".data"}, res_data, e);
            for (int k = 0; k < hold_cycles; k++) begin
                start = (k == 1);
                tick();
                check({tag, ".hold_rv"}, res_valid, 1);
                check({tag, ".hold_data"}, res_data, e);
                check({tag, ".hold_sr"}, start_ready, 0);
            end
            start = 1'b0;
            if (reset_in_hold) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                check({tag, ".rst_data"}, res_data, 0);
            end else begin
                res_ready = 1'b1;
                tick();
                res_ready = 1'b0;
            end
            check({tag, ".rel_rv"}, res_valid, 0);
            check({tag, ".rel_sr"}, start_ready, 1);
            check({tag, ".rel_err"}, err, 0);
        end else begin
            void'(exp_q.pop_front());
            check({tag, ".no_result"}, 0, 1);
        end
    endtask

    initial begin
        digits_t d;
        reset     = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        in_digit  = '0;
        in_valid  = 1'b0;
        res_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        check("rst.start_ready", start_ready, 1);
        check("rst.conv_reset", conv_reset, 1);
        check("rst.in_ready", in_ready, 0);
        check("rst.res_valid", res_valid, 0);
        check("rst.res_data", res_data, 0);
        check("rst.err", err, 0);
        check("rst.err_code", err_code, 0);

        // All +1 digits.
        for (int i = 0; i < N; i++) d[i] = 3'd1;
        run_word("ones", d, 16'h5555, 0, 1'b0);

        // Leading negative digit.
        for (int i = 0; i < N; i++) d[i] = 3'd0;
        d[0] = 3'b111;
        run_word("neg1", d, 16'hC000, 0, 1'b0);

        // 2 followed by -1 borrows into the top digit.
        d[0] = 3'd2;
        d[1] = 3'b111;
        run_word("two_m1", d, 16'h7000, 5, 1'b0);

        // Random legal digits against the reference model.
        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < N; i++) d[i] = RB'($urandom_range(0, 6) - 3);
            run_word("rand", d, ref_word(d), w, 1'b0);
        end

        // Stream gap after three digits.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_digit = 3'd1;
            tick();
        end
        in_valid = 1'b0;
        #1;
        check("gap.conv_reset", conv_reset, 1);
        check("gap.in_ready", in_ready, 1);
        tick();
        check("gap.err", err, 1);
        check("gap.err_code", err_code, 1);
        check("gap.start_ready", start_ready, 1);
        check("gap.res_valid", res_valid, 0);
        tick();
        check("gap.err_pulse", err, 0);
        check("gap.code_held", err_code, 1);

        // First-digit timeout.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("to.code_clr", err_code, 0);
        for (int i = 0; i < 14; i++) tick();
        check("to.not_yet", err, 0);
        check("to.in_ready", in_ready, 1);
        check("to.conv_reset", conv_reset, 1);
        tick();
        check("to.err", err, 1);
        check("to.err_code", err_code, 2);
        check("to.start_ready", start_ready, 1);

        // Illegal first digit.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ill.code_clr", err_code, 0);
        in_valid = 1'b1;
        in_digit = 3'b100;
        #1;
        check("ill.conv_reset", conv_reset, 1);
        tick();
        in_valid = 1'b0;
        in_digit = '0;
        check("ill.err", err, 1);
        check("ill.err_code", err_code, 3);
        check("ill.start_ready", start_ready, 1);

        // Abort mid-CONVERT.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_digit = 3'd2;
            tick();
        end
        abort = 1'b1;
        #1;
        check("abort.conv_reset", conv_reset, 1);
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        check("abort.start_ready", start_ready, 1);
        check("abort.err", err, 0);
        check("abort.err_code", err_code, 0);
        check("abort.res_valid", res_valid, 0);

        // Word after abort, then reset while the result is held.
        for (int i = 0; i < N; i++) d[i] = RB'(i % 7 - 3);
        run_word("post_abort", d, ref_word(d), 2, 1'b1);

        // Word after reset.
        for (int i = 0; i < N; i++) d[i] = 3'd3;
        run_word("post_reset", d, ref_word(d), 1, 1'b0);

        check("sb.empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    // Hard bound in case the stimulus itself stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
